// File: rtl/softmax_norm_requester_if.sv
// Stream and reciprocal-request signals of the SoftMax normalisation back end.
// slave is the block side, master is the environment side.
interface softmax_norm_requester_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] rec_number;
    logic                  rec_enable;
    logic [DATA_WIDTH-1:0] rec_result;
    logic                  rec_ack;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;
    logic                  err_timeout;
    logic                  err_zero;

    modport master (
        output in_valid, in_data, rec_result, rec_ack, out_ready,
        input  in_ready, rec_number, rec_enable,
        input  out_valid, out_data, out_last, err_timeout, err_zero
    );

    modport slave (
        input  in_valid, in_data, rec_result, rec_ack, out_ready,
        output in_ready, rec_number, rec_enable,
        output out_valid, out_data, out_last, err_timeout, err_zero
    );
endinterface

// File: rtl/softmax_norm_requester.sv
// SoftMax normaliser: sums N exponentials, requests 1/sum, streams x*(1/sum).
// Includes the combinational floatAdd/floatMult cells it is built on.
module floatAdd (
    input  logic [31:0] floatA,
    input  logic [31:0] floatB,
    output logic [31:0] sum
);
    logic [31:0] big, sml;
    logic [7:0]  e, d;
    logic [24:0] mb, ms, m;

    always_comb begin
        big = floatA;
        sml = floatB;
        if (floatB[30:0] > floatA[30:0]) begin
            big = floatB;
            sml = floatA;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b0, |big[30:23], big[22:0]};
        ms = {1'b0, |sml[30:23], sml[22:0]};
        ms = (d > 8'd24) ? '0 : ms >> d;
        m  = (big[31] == sml[31]) ? mb + ms : mb - ms;
        e  = big[30:23];
        if (m[24]) begin
            m = m >> 1;
            e = e + 8'd1;
        end
        for (int i = 0; i < 24; i++) begin
            if (!m[23] && m != '0 && e > 8'd1) begin
                m = m << 1;
                e = e - 8'd1;
            end
        end
        sum = (m == '0) ? 32'd0 : {big[31], e, m[22:0]};
    end
endmodule

module floatMult (
    input  logic [31:0] floatA,
    input  logic [31:0] floatB,
    output logic [31:0] product
);
    logic [47:0] p;
    logic [24:0] ph;
    logic [9:0]  ee;
    logic        s;

    always_comb begin
        s  = floatA[31] ^ floatB[31];
        p  = {24'd0, |floatA[30:23], floatA[22:0]}
           * {24'd0, |floatB[30:23], floatB[22:0]};
        ph = 25'(p >> 23);
        ee = {2'b0, floatA[30:23]} + {2'b0, floatB[30:23]} + {9'd0, ph[24]};
        product = {s, 31'd0};
        if (floatA[30:23] == 8'd0 || floatB[30:23] == 8'd0 || ee <= 10'd127)
            product = {s, 31'd0};
        else if (ee >= 10'd382)
            product = {s, 8'hFF, 23'd0};
        else
            product = {s, 8'(ee - 10'd127), ph[24] ? ph[23:1] : ph[22:0]};
    end
endmodule

module softmax_norm_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 10,
    parameter int TIMEOUT    = 64
) (
    input logic                    clk,
    input logic                    rst_n,
    softmax_norm_requester_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST  = CW'(N - 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] ACCUM     = 2'd0;
    localparam logic [1:0] REQ_SETUP = 2'd1;
    localparam logic [1:0] REQ_WAIT  = 2'd2;
    localparam logic [1:0] EMIT      = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         cnt, idx, nidx;
    logic [WW-1:0]         wcnt;
    logic                  setup;
    logic [DATA_WIDTH-1:0] sum, recip, add_a, add_res, mul_res;
    logic [DATA_WIDTH-1:0] rec_number, out_data;
    logic                  out_valid, err_timeout, err_zero;
    logic [DATA_WIDTH-1:0] ebuf [N];
    logic                  take;

    assign bus.in_ready    = (state == ACCUM);
    assign bus.rec_enable  = (state == REQ_WAIT);
    assign bus.rec_number  = rec_number;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_last    = out_valid && (idx == LAST);
    assign bus.err_timeout = err_timeout;
    assign bus.err_zero    = err_zero;

    assign take  = bus.in_valid && (state == ACCUM);
    assign add_a = (cnt == '0) ? '0 : sum;
    assign nidx  = (out_valid && idx != LAST) ? idx + CW'(1) : '0;

    floatAdd  u_add (.floatA(add_a), .floatB(bus.in_data), .sum(add_res));
    floatMult u_mul (.floatA(ebuf[nidx]), .floatB(recip), .product(mul_res));

    always_ff @(posedge clk) begin
        if (take)
            ebuf[cnt] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            cnt         <= '0;
            idx         <= '0;
            wcnt        <= '0;
            setup       <= 1'b0;
            sum         <= '0;
            recip       <= '0;
            rec_number  <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_zero    <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ACCUM): begin
                    if (take) begin
                        sum <= add_res;
                        cnt <= cnt + CW'(1);
                        if (cnt == '0) begin
                            err_timeout <= 1'b0;
                            err_zero    <= 1'b0;
                        end
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (add_res[30:0] == '0) begin
                                recip    <= '0;
                                err_zero <= 1'b1;
                                state    <= EMIT;
                            end else begin
                                // operand settles before both enable-low cycles
                                rec_number <= add_res;
                                setup      <= 1'b0;
                                state      <= REQ_SETUP;
                            end
                        end
                    end
                end
                (state == REQ_SETUP): begin
                    rec_number <= sum;
                    setup      <= 1'b1;
                    wcnt       <= '0;
                    if (setup)
                        state <= REQ_WAIT;
                end
                (state == REQ_WAIT): begin
                    wcnt <= wcnt + WW'(1);
                    if (bus.rec_ack && wcnt != '0) begin
                        recip <= bus.rec_result;
                        state <= EMIT;
                    end else if (wcnt == WLAST) begin
                        recip       <= bus.rec_result;
                        err_timeout <= 1'b1;
                        state       <= EMIT;
                    end
                end
                (state == EMIT): begin
                    if (!out_valid) begin
                        out_data  <= mul_res;
                        out_valid <= 1'b1;
                        idx       <= '0;
                    end else if (bus.out_ready) begin
                        if (idx != LAST) begin
                            idx      <= idx + CW'(1);
                            out_data <= mul_res;
                        end else begin
                            out_valid <= 1'b0;
                            idx       <= '0;
                            cnt       <= '0;
                            sum       <= '0;
                            state     <= ACCUM;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_norm_requester.sv
// Directed bench for softmax_norm_requester (N=4, TIMEOUT=16).
// Drives a reciprocal responder model and monitors the request protocol.
module tb_softmax_norm_requester;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    softmax_norm_requester_if #(.DATA_WIDTH(32)) bus ();

    softmax_norm_requester #(
        .DATA_WIDTH(32),
        .N         (4),
        .TIMEOUT   (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int ack_dly = 0;
    int en_age = 0;
    int rises = 0;
    int hi_cnt = 0;
    int low_cnt = 0;
    logic prev_en = 1'b0;
    logic [31:0] prev_num = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // responder: acks ack_dly cycles after enable rises (0 = never)
    always @(posedge clk or negedge rst_n)
        if (!rst_n) en_age <= 0;
        else        en_age <= bus.rec_enable ? en_age + 1 : 0;

    assign bus.rec_ack = (ack_dly > 0) && bus.rec_enable && (en_age >= ack_dly);

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en  <= 1'b0;
            low_cnt  <= 0;
            prev_num <= bus.rec_number;
        end else begin
            prev_en  <= bus.rec_enable;
            prev_num <= bus.rec_number;
            if (bus.rec_enable || bus.out_valid)
                check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            if (bus.rec_enable) begin
                low_cnt <= 0;
                if (!prev_en) begin
                    rises  <= rises + 1;
                    hi_cnt <= 1;
                    check("setup_low",
                          32'(low_cnt >= 2 && bus.rec_number === prev_num), 32'd1);
                end else begin
                    hi_cnt <= hi_cnt + 1;
                    check("num_stable", bus.rec_number, prev_num);
                end
            end else begin
                low_cnt <= (bus.rec_number === prev_num) ? low_cnt + 1 : 1;
            end
        end
    end

    task automatic send(input logic [31:0] d);
        check("in_ready_acc", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp,
                              input logic last, input logic stall);
        int n;
        wait_valid(n);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, bus.out_data, exp);
        check({tag, "_last"}, 32'(bus.out_last), 32'(last));
        if (stall) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, bus.out_data, exp);
            check({tag, "_hold_last"}, 32'(bus.out_last), 32'(last));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int r0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.rec_result = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_rec_enable", 32'(bus.rec_enable), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_rec_number", bus.rec_number, 32'd0);
        check("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        check("rst_err_zero", 32'(bus.err_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1+1+1+1 = 4, responder returns 0.25 after 5 cycles
        ack_dly = 5;
        bus.rec_result = 32'h3E800000;
        for (int i = 0; i < 4; i++) send(32'h3F800000);
        wait_valid(n);
        check("lat_ack", n, 32'd9);
        check("rec_number", bus.rec_number, 32'h40800000);
        check("en_cycles_ack", hi_cnt, 32'd6);
        check("rises_a", rises, 32'd1);
        for (int i = 0; i < 4; i++)
            expect_out("out_a", 32'h3E800000, 1'(i == 3), 1'b0);
        check("a_done_valid", 32'(bus.out_valid), 32'd0);
        check("a_in_ready", 32'(bus.in_ready), 32'd1);
        check("a_err_timeout", 32'(bus.err_timeout), 32'd0);
        check("a_err_zero", 32'(bus.err_zero), 32'd0);

        // same frame with a one-cycle stall on every word
        for (int i = 0; i < 4; i++) send(32'h3F800000);
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid)
                check("b_in_ready_busy", 32'(bus.in_ready), 32'd0);
            expect_out("out_b", 32'h3E800000, 1'(i == 3), 1'b1);
        end
        check("b_done_valid", 32'(bus.out_valid), 32'd0);
        check("b_in_ready", 32'(bus.in_ready), 32'd1);
        check("rises_b", rises, 32'd2);

        // responder never acks: 16 enable cycles, last rec_result used
        ack_dly = 0;
        bus.rec_result = 32'h3E7FFFFF;
        for (int i = 0; i < 4; i++) send(32'h3F800000);
        wait_valid(n);
        check("lat_timeout", n, 32'd19);
        check("en_cycles_to", hi_cnt, 32'd16);
        check("to_err_timeout", 32'(bus.err_timeout), 32'd1);
        check("to_err_zero", 32'(bus.err_zero), 32'd0);
        for (int i = 0; i < 4; i++)
            expect_out("out_to", 32'h3E7FFFFF, 1'(i == 3), 1'b0);
        check("to_err_hold", 32'(bus.err_timeout), 32'd1);

        // zero sum: no request, zeros out, err_zero
        r0 = rises;
        send(32'h00000000);
        check("z_err_cleared", 32'(bus.err_timeout), 32'd0);
        for (int i = 0; i < 3; i++) send(32'h00000000);
        wait_valid(n);
        check("lat_zero", n, 32'd1);
        check("z_err_zero", 32'(bus.err_zero), 32'd1);
        for (int i = 0; i < 4; i++)
            expect_out("out_z", 32'h00000000, 1'(i == 3), 1'b0);
        check("z_no_request", rises, r0);
        check("z_err_timeout", 32'(bus.err_timeout), 32'd0);

        // reset in the 3rd REQ_WAIT cycle
        ack_dly = 0;
        for (int i = 0; i < 4; i++) send(32'h3F800000);
        n = 0;
        while (!bus.rec_enable && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("r_enable_up", 32'(bus.rec_enable), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("r_enable_drop", 32'(bus.rec_enable), 32'd0);
        check("r_in_ready", 32'(bus.in_ready), 32'd1);
        check("r_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("r_in_ready_rel", 32'(bus.in_ready), 32'd1);

        // 2+2+2+2 = 8, responder returns 0.125 -> 2*0.125 = 0.25
        ack_dly = 2;
        bus.rec_result = 32'h3E000000;
        for (int i = 0; i < 4; i++) send(32'h40000000);
        wait_valid(n);
        check("lat_post_rst", n, 32'd6);
        check("r_rec_number", bus.rec_number, 32'h41000000);
        for (int i = 0; i < 4; i++)
            expect_out("out_r", 32'h3E800000, 1'(i == 3), 1'b0);
        check("r_done_valid", 32'(bus.out_valid), 32'd0);
        check("r_err_timeout", 32'(bus.err_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
